// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM states and
// default frame geometry.
package uart_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bus of uart_rx: the received byte plus its status strobes.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 parity_err;

    modport master (output rx_data, rx_valid, rx_busy, frame_err, parity_err);
    modport slave  (input  rx_data, rx_valid, rx_busy, frame_err, parity_err);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit, with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB first, mid-bit sampling on tick_16x.
// Define UART_RX_PARITY_EN to add an even-parity bit ahead of the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      tick_16x,
    input  logic      rx_pin,
    uart_rx_if.master bus
);

    localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 valid_q;
    logic                 busy_q;
    logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 perr_q;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_pin),
        .q     (rx_s)
    );

    assign cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            data_q  <= '0;
            rx_prev <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rx_prev <= rx_s;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            // State entries below override this free-running advance with a clear.
            if (tick_16x) begin
                cnt <= cnt_next;
            end

            case (state)
                IDLE: begin
                    // Edge-triggered so a held-low (break) line cannot restart a frame.
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (tick_16x && cnt == CNT_MID) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            busy_q  <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                DATA: begin
                    if (tick_16x && cnt == CNT_LAST) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_LAST) begin
                            cnt   <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_16x && cnt == CNT_LAST) begin
                        par_bit <= rx_s;
                        cnt     <= '0;
                        state   <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (tick_16x && cnt == CNT_LAST) begin
                        if (rx_s) begin
                            data_q  <= shreg;
                            valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_q  <= ^{shreg, par_bit};
`endif
                        end else begin
                            ferr_q <= 1'b1;
                        end
                        busy_q <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    busy_q <= 1'b0;
                    cnt    <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.rx_busy   = busy_q;
    assign bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frames, false start, framing error,
// parity, mid-frame reset and back-to-back frames.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int PERR_TOTAL_EXP = 1;
`else
    localparam int PERR_TOTAL_EXP = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic tick_16x;
    logic rx_pin;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick_16x (tick_16x),
        .rx_pin   (rx_pin),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        tick_16x = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            tick_16x = 1'b1;
            @(negedge clk);
            tick_16x = 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Output monitor, sampled on the falling edge
    int         cyc = 0;
    int         n_valid, n_ferr, n_perr, n_same, n_perr_total = 0;
    int         valid_cyc;
    logic       busy_seen;
    logic [7:0] cap[$];

    task automatic clear_mon();
        n_valid = 0; n_ferr = 0; n_perr = 0; n_same = 0;
        busy_seen = 1'b0;
        cap.delete();
    endtask

    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.rx_valid) begin
                n_valid++;
                valid_cyc = cyc;
                cap.push_back(bus.rx_data);
                if (bus.parity_err) n_same++;
            end
            if (bus.frame_err) n_ferr++;
            if (bus.parity_err) begin
                n_perr++;
                n_perr_total++;
            end
            if (bus.rx_busy) busy_seen = 1'b1;
        end
    end

    task automatic drive_bit(input logic b);
        rx_pin = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity disabled, parity flip has no effect");
`endif
        drive_bit(stop);
    endtask

    int edge_cyc;
    int lat;

    initial begin
        reset  = 1'b1;
        rx_pin = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data",  32'(bus.rx_data),    32'h0);
        check("rst_valid", 32'(bus.rx_valid),   32'h0);
        check("rst_busy",  32'(bus.rx_busy),    32'h0);
        check("rst_ferr",  32'(bus.frame_err),  32'h0);
        check("rst_perr",  32'(bus.parity_err), 32'h0);
        reset = 1'b0;
        drive_bit(1'b1);

        // Clean 0x55 frame and its latency from the start edge
        clear_mon();
        edge_cyc = cyc;
        send_frame(8'h55, 1'b1, 1'b0);
        lat = valid_cyc - edge_cyc;
        check("f55_data",   32'(bus.rx_data), 32'h55);
        check("f55_nvalid", 32'(n_valid),     32'd1);
        check("f55_ferr",   32'(n_ferr),      32'd0);
        check("f55_lat_ok", 32'(lat >= 600 && lat <= 620), 32'd1);
        check("f55_busy_seen", 32'(busy_seen),   32'd1);
        check("f55_busy_end",  32'(bus.rx_busy), 32'd0);
        drive_bit(1'b1);

        // False start: 4-tick low glitch
        clear_mon();
        rx_pin = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("glitch_busy",  32'(busy_seen), 32'd0);
        check("glitch_valid", 32'(n_valid),   32'd0);
        check("glitch_ferr",  32'(n_ferr),    32'd0);
        check("glitch_idle",  32'(dut.state), 32'(IDLE));

        // 0xA5 with a low stop bit
        clear_mon();
        send_frame(8'hA5, 1'b0, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("ferr_count", 32'(n_ferr),      32'd1);
        check("ferr_valid", 32'(n_valid),     32'd0);
        check("ferr_keep",  32'(bus.rx_data), 32'h55);
        check("ferr_busy",  32'(bus.rx_busy), 32'd0);

        // 0xA5 with the parity bit inverted (wrong parity when enabled)
        clear_mon();
        send_frame(8'hA5, 1'b1, 1'b1);
        drive_bit(1'b1);
        check("par_data",   32'(bus.rx_data), 32'hA5);
        check("par_nvalid", 32'(n_valid),     32'd1);
        check("par_perr",   32'(n_perr),      32'(PERR_TOTAL_EXP));
        check("par_same",   32'(n_same),      32'(PERR_TOTAL_EXP));

        // Asynchronous reset in the middle of bit 4
        clear_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx_pin = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("mid_busy_before", 32'(bus.rx_busy), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_data",  32'(bus.rx_data),    32'h0);
        check("mid_rst_valid", 32'(bus.rx_valid),   32'h0);
        check("mid_rst_busy",  32'(bus.rx_busy),    32'h0);
        check("mid_rst_ferr",  32'(bus.frame_err),  32'h0);
        check("mid_rst_perr",  32'(bus.parity_err), 32'h0);
        check("mid_rst_state", 32'(dut.state),      32'(IDLE));
        repeat (4) @(negedge clk);
        reset = 1'b0;
        drive_bit(1'b1);
        clear_mon();
        send_frame(8'h3C, 1'b1, 1'b0);
        drive_bit(1'b1);
        check("post_rst_data",   32'(bus.rx_data), 32'h3C);
        check("post_rst_nvalid", 32'(n_valid),     32'd1);
        check("post_rst_ferr",   32'(n_ferr),      32'd0);

        // Back-to-back frames, no idle gap
        clear_mon();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drive_bit(1'b1);
        check("b2b_nvalid", 32'(n_valid), 32'd2);
        check("b2b_first",  32'((cap.size() > 0) ? cap[0] : 8'hEE), 32'h00);
        check("b2b_second", 32'((cap.size() > 1) ? cap[1] : 8'hEE), 32'hFF);
        check("b2b_ferr",   32'(n_ferr),  32'd0);

        check("perr_total", 32'(n_perr_total), 32'(PERR_TOTAL_EXP));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
